// File: rtl/spi_matrix_receiver.sv
// SPI-slave matrix loader: one header word, then A and B row-major, one 32-bit word per SPI frame.
// spi_slave oversamples a mode-0, MSB-first link in the clk domain and hands words over with rx_valid/rx_ready.

module spi_slave (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [31:0] rx_data
);
    logic [2:0]  sclk_sync;
    logic [2:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic [4:0]  bit_cnt;
    logic [30:0] shift;
    logic [31:0] tx_shift;
    logic        sclk_rise, sclk_fall, cs_active, cs_start, mosi_bit;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_active = ~cs_sync[1];
    assign cs_start  = ~cs_sync[1] & cs_sync[2];
    assign mosi_bit  = mosi_sync[1];
    assign miso      = tx_shift[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_shift  <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (!cs_active) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift   <= {shift[29:0], mosi_bit};
                bit_cnt <= bit_cnt + 5'd1;
                // A word completing while the previous one is still held is dropped.
                if (bit_cnt == 5'd31 && (!rx_valid || rx_ready)) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {shift, mosi_bit};
                end
            end
            if (cs_start)
                tx_shift <= tx_valid ? tx_data : '0;
            else if (cs_active && sclk_fall)
                tx_shift <= {tx_shift[30:0], 1'b0};
        end
    end
endmodule

module spi_matrix_receiver #(
    parameter int MAX_M = 10,
    parameter int MAX_K = 10,
    parameter int MAX_N = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso,
    input  logic        start_rx,
    output logic [31:0] matrix_A [0:MAX_M*MAX_K-1],
    output logic [31:0] matrix_B [0:MAX_K*MAX_N-1],
    output logic [7:0]  M_out,
    output logic [7:0]  K_out,
    output logic [7:0]  N_out,
    output logic [15:0] C_size,
    output logic        busy,
    output logic        done_rx,
    output logic        err_hdr
);
    localparam int A_DEPTH = MAX_M * MAX_K;
    localparam int B_DEPTH = MAX_K * MAX_N;
    localparam int AW      = $clog2(A_DEPTH);
    localparam int BW      = $clog2(B_DEPTH);
    localparam int IW      = (AW > BW) ? AW : BW;
    localparam logic [7:0] MAX_M8 = 8'(MAX_M);
    localparam logic [7:0] MAX_K8 = 8'(MAX_K);
    localparam logic [7:0] MAX_N8 = 8'(MAX_N);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD_A, S_LOAD_B, S_DONE, S_ERR} state_t;

    state_t        state, state_next;
    logic [IW-1:0] idx;
    logic          rx_valid, rx_ready, xfer, hdr_ok;
    logic [31:0]   rx_data;
    logic [31:0]   tx_data;
    logic          tx_valid;
    logic [7:0]    hdr_m, hdr_k, hdr_n;
    logic [15:0]   a_last, b_last;

    assign tx_valid = 1'b0;
    assign tx_data  = '0;

    spi_slave u_spi (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .miso     (miso),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    assign hdr_m  = rx_data[31:24];
    assign hdr_k  = rx_data[23:16];
    assign hdr_n  = rx_data[15:8];
    assign hdr_ok = (rx_data[7:0] == 8'hA5)
                  && (hdr_m != 8'd0) && (hdr_m <= MAX_M8)
                  && (hdr_k != 8'd0) && (hdr_k <= MAX_K8)
                  && (hdr_n != 8'd0) && (hdr_n <= MAX_N8);

    assign a_last   = 16'(M_out) * 16'(K_out) - 16'd1;
    assign b_last   = 16'(K_out) * 16'(N_out) - 16'd1;
    // ERR keeps draining the link so a stale frame cannot be mistaken for the next header.
    assign rx_ready = (state == S_HDR) || (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_ERR);
    assign xfer     = rx_valid && rx_ready;
    assign busy     = (state == S_HDR) || (state == S_LOAD_A) || (state == S_LOAD_B);
    assign done_rx  = (state == S_DONE);

    // NOTE: every combinational output gets its default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_rx) state_next = S_HDR;
            S_HDR:    if (xfer) state_next = hdr_ok ? S_LOAD_A : S_ERR;
            S_LOAD_A: if (xfer && 16'(idx) == a_last) state_next = S_LOAD_B;
            S_LOAD_B: if (xfer && 16'(idx) == b_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            S_ERR:    if (start_rx) state_next = S_HDR;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            M_out   <= '0;
            K_out   <= '0;
            N_out   <= '0;
            C_size  <= '0;
            err_hdr <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_ERR: begin
                    if (start_rx) begin
                        err_hdr <= 1'b0;
                        idx     <= '0;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        if (hdr_ok) begin
                            M_out  <= hdr_m;
                            K_out  <= hdr_k;
                            N_out  <= hdr_n;
                            C_size <= 16'(hdr_m) * 16'(hdr_n);
                            idx    <= '0;
                        end else begin
                            err_hdr <= 1'b1;
                        end
                    end
                end
                S_LOAD_A: if (xfer) idx <= (16'(idx) == a_last) ? '0 : idx + 1'b1;
                S_LOAD_B: if (xfer) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: operand storage has no reset; its contents are only meaningful once done_rx qualifies them.
    always_ff @(posedge clk) begin
        if (xfer && state == S_LOAD_A)
            matrix_A[idx[AW-1:0]] <= rx_data;
        if (xfer && state == S_LOAD_B)
            matrix_B[idx[BW-1:0]] <= rx_data;
    end
endmodule

// File: tb/tb_spi_matrix_receiver.sv
// Self-checking bench for spi_matrix_receiver: drives SPI frames and compares against a job-level model.
// The model records what each accepted job must leave in storage and on the dimension outputs.

module tb_spi_matrix_receiver;
    localparam int MAX_M = 10;
    localparam int MAX_K = 10;
    localparam int MAX_N = 10;
    localparam int A_DEPTH = MAX_M * MAX_K;
    localparam int B_DEPTH = MAX_K * MAX_N;
    // Final sclk rise -> 2 sync flops + word assembly -> transfer -> DONE.
    localparam int DONE_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n, sclk, mosi, cs_n, start_rx;
    logic        miso, busy, done_rx, err_hdr;
    logic [31:0] matrix_A [0:A_DEPTH-1];
    logic [31:0] matrix_B [0:B_DEPTH-1];
    logic [7:0]  M_out, K_out, N_out;
    logic [15:0] C_size;

    spi_matrix_receiver #(.MAX_M(MAX_M), .MAX_K(MAX_K), .MAX_N(MAX_N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .miso     (miso),
        .start_rx (start_rx),
        .matrix_A (matrix_A),
        .matrix_B (matrix_B),
        .M_out    (M_out),
        .K_out    (K_out),
        .N_out    (N_out),
        .C_size   (C_size),
        .busy     (busy),
        .done_rx  (done_rx),
        .err_hdr  (err_hdr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] exp_a [A_DEPTH];
    logic [31:0] exp_b [B_DEPTH];
    bit          known_a [A_DEPTH];
    bit          known_b [B_DEPTH];
    int          exp_m, exp_k, exp_n, exp_csize;
    logic [31:0] job_q[$];

    // Cycle counter and done_rx monitor
    int   cyc = 0;
    int   done_count = 0;
    int   done_wide = 0;
    int   done_cyc = 0;
    int   last_rise_cyc = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_rx && !done_prev) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
        if (done_rx && done_prev)
            done_wide <= done_wide + 1;
        done_prev <= done_rx;
    end

    function automatic int storage_errors();
        int bad = 0;
        for (int i = 0; i < A_DEPTH; i++)
            if (known_a[i] && matrix_A[i] !== exp_a[i]) bad++;
        for (int i = 0; i < B_DEPTH; i++)
            if (known_b[i] && matrix_B[i] !== exp_b[i]) bad++;
        return bad;
    endfunction

    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 31; i >= 0; i--) begin
            mosi = w[i];
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            if (i == 0) last_rise_cyc = cyc;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_rx = 1'b1;
        @(negedge clk);
        start_rx = 1'b0;
    endtask

    task automatic fill_random(input int cnt);
        job_q.delete();
        for (int i = 0; i < cnt; i++) job_q.push_back($urandom);
    endtask

    // Sends a valid header then up to 'limit' words of job_q, updating the model for what was sent.
    task automatic send_job(input int m, input int k, input int n, input int limit);
        int na = m * k;
        send_word({8'(m), 8'(k), 8'(n), 8'hA5});
        exp_m = m; exp_k = k; exp_n = n; exp_csize = m * n;
        for (int i = 0; i < job_q.size() && i < limit; i++) begin
            if (i < na) begin
                exp_a[i] = job_q[i]; known_a[i] = 1'b1;
            end else begin
                exp_b[i - na] = job_q[i]; known_b[i - na] = 1'b1;
            end
            send_word(job_q[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; start_rx = 1'b0;
        exp_m = 0; exp_k = 0; exp_n = 0; exp_csize = 0;
        for (int i = 0; i < A_DEPTH; i++) known_a[i] = 1'b0;
        for (int i = 0; i < B_DEPTH; i++) known_b[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({M_out, K_out, N_out} !== 24'd0) begin n_err++; $display("FAIL reset_dims: got %h want 000000", {M_out, K_out, N_out}); end
        n_cmp++; if (C_size !== 16'd0) begin n_err++; $display("FAIL reset_csize: got %0d want 0", C_size); end
        n_cmp++; if ({busy, done_rx, err_hdr} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done_rx, err_hdr}); end
        n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", miso); end
    endtask

    task automatic check_job(input string name, input int d0);
        n_cmp++; if (M_out !== 8'(exp_m) || K_out !== 8'(exp_k) || N_out !== 8'(exp_n)) begin
            n_err++; $display("FAIL %s_dims: got %0d/%0d/%0d want %0d/%0d/%0d", name, M_out, K_out, N_out, exp_m, exp_k, exp_n);
        end
        n_cmp++; if (C_size !== 16'(exp_csize)) begin n_err++; $display("FAIL %s_csize: got %0d want %0d", name, C_size, exp_csize); end
        n_cmp++; if (storage_errors() !== 0) begin n_err++; $display("FAIL %s_storage: got %0d bad entries want 0", name, storage_errors()); end
        n_cmp++; if (done_count - d0 !== 1) begin n_err++; $display("FAIL %s_done_count: got %0d want 1", name, done_count - d0); end
        n_cmp++; if (done_wide !== 0) begin n_err++; $display("FAIL %s_done_width: got %0d extra cycles want 0", name, done_wide); end
        n_cmp++; if (done_cyc - last_rise_cyc !== DONE_LAT) begin n_err++; $display("FAIL %s_done_latency: got %0d want %0d", name, done_cyc - last_rise_cyc, DONE_LAT); end
        n_cmp++; if (busy !== 1'b0 || err_hdr !== 1'b0) begin n_err++; $display("FAIL %s_idle_flags: got busy=%b err=%b want 0 0", name, busy, err_hdr); end
    endtask

    task automatic test_basic();
        int d0 = done_count;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_hdr: got %b want 1", busy); end
        job_q.delete();
        for (int i = 1; i <= 12; i++) job_q.push_back(32'(i));
        send_job(2, 3, 2, 12);
        check_job("basic", d0);
    endtask

    task automatic test_bad_sync();
        int d0 = done_count;
        logic [31:0] hdr;
        pulse_start();
        hdr = 32'h01010100;
        send_word(hdr);
        n_cmp++; if (err_hdr !== 1'b1) begin n_err++; $display("FAIL badsync_err: got %b want 1", err_hdr); end
        n_cmp++; if (M_out !== 8'(exp_m) || K_out !== 8'(exp_k) || N_out !== 8'(exp_n) || C_size !== 16'(exp_csize)) begin
            n_err++; $display("FAIL badsync_dims: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", M_out, K_out, N_out, C_size, exp_m, exp_k, exp_n, exp_csize);
        end
        // In-range dimensions with a wrong sync byte must not be latched either.
        pulse_start();
        hdr = {8'($urandom_range(3, 9)), 8'($urandom_range(4, 9)), 8'($urandom_range(3, 9)), 8'h5A};
        send_word(hdr);
        n_cmp++; if (err_hdr !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL badsync2_flags: got err=%b busy=%b want 1 0", err_hdr, busy); end
        n_cmp++; if (M_out !== 8'(exp_m) || K_out !== 8'(exp_k) || N_out !== 8'(exp_n)) begin
            n_err++; $display("FAIL badsync2_dims: got %0d/%0d/%0d want %0d/%0d/%0d", M_out, K_out, N_out, exp_m, exp_k, exp_n);
        end
        n_cmp++; if (done_count !== d0) begin n_err++; $display("FAIL badsync_done: got %0d pulses want 0", done_count - d0); end
    endtask

    task automatic test_err_recovery();
        int d0 = done_count;
        pulse_start();
        send_word(32'h0B0101A5);
        n_cmp++; if (err_hdr !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL err_flags: got err=%b busy=%b want 1 0", err_hdr, busy); end
        for (int i = 0; i < 5; i++) send_word($urandom);
        n_cmp++; if (storage_errors() !== 0) begin n_err++; $display("FAIL err_discard_storage: got %0d bad entries want 0", storage_errors()); end
        n_cmp++; if (err_hdr !== 1'b1 || done_count !== d0) begin n_err++; $display("FAIL err_sticky: got err=%b done=%0d want 1 0", err_hdr, done_count - d0); end
        pulse_start();
        n_cmp++; if (err_hdr !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL err_restart: got err=%b busy=%b want 0 1", err_hdr, busy); end
        job_q.delete();
        job_q.push_back(32'hAA);
        job_q.push_back(32'hBB);
        send_job(1, 1, 1, 2);
        check_job("err_recover", d0);
    endtask

    task automatic test_max();
        int d0 = done_count;
        pulse_start();
        fill_random(A_DEPTH + B_DEPTH);
        send_job(10, 10, 10, A_DEPTH + B_DEPTH);
        check_job("max", d0);
    endtask

    task automatic test_reset_mid_load();
        int d0;
        pulse_start();
        fill_random(12);
        send_job(2, 3, 2, 4);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({M_out, K_out, N_out, C_size} !== 40'd0 || {busy, done_rx, err_hdr} !== 3'b000) begin
            n_err++; $display("FAIL midrst_outputs: got %h %b want 0 000", {M_out, K_out, N_out, C_size}, {busy, done_rx, err_hdr});
        end
        exp_m = 0; exp_k = 0; exp_n = 0; exp_csize = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (storage_errors() !== 0) begin n_err++; $display("FAIL midrst_partial: got %0d bad entries want 0", storage_errors()); end
        d0 = done_count;
        pulse_start();
        fill_random(12);
        send_job(2, 3, 2, 12);
        check_job("after_reset", d0);
    endtask

    task automatic test_start_ignored();
        int d0 = done_count;
        int waited = 0;
        int na = 6;
        pulse_start();
        fill_random(12);
        send_word(32'h020302A5);
        exp_m = 2; exp_k = 3; exp_n = 2; exp_csize = 4;
        for (int i = 0; i < 11; i++) begin
            if (i < na) begin
                pulse_start();
                exp_a[i] = job_q[i]; known_a[i] = 1'b1;
            end else begin
                exp_b[i - na] = job_q[i]; known_b[i - na] = 1'b1;
            end
            send_word(job_q[i]);
        end
        exp_b[5] = job_q[11]; known_b[5] = 1'b1;
        // start_rx held through the final B transfer and the DONE cycle, dropped before IDLE samples it.
        start_rx = 1'b1;
        fork
            send_word(job_q[11]);
            begin
                while (!done_rx && waited < 2000) begin
                    @(negedge clk);
                    waited++;
                end
                start_rx = 1'b0;
            end
        join
        n_cmp++; if (waited >= 2000) begin n_err++; $display("FAIL startign_timeout: got no done_rx within %0d cycles want one", waited); end
        repeat (3) @(negedge clk);
        check_job("start_ignored", d0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 3; j++) begin
            int d0 = done_count;
            int m = $urandom_range(1, 4);
            int k = $urandom_range(1, 4);
            int n = $urandom_range(1, 4);
            pulse_start();
            fill_random(m * k + k * n);
            send_job(m, k, n, m * k + k * n);
            check_job("random", d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_sync();
        test_err_recovery();
        test_max();
        test_reset_mid_load();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
